// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (signed or unsigned), one quotient bit per unstalled cycle.
// Optional macro DIV_BY_ZERO_EN adds a dz flag and a short-cut finish for a zero divisor.
module div_seq #(
    parameter bit SIGNED_OP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    input  logic        cpu_stall,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        busy,
`ifdef DIV_BY_ZERO_EN
    output logic        dz,
`endif
    output logic        finish
);

    // IDLE: waiting for start | CALC: 32 shift/subtract steps | DONE: publish results
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    logic        r_last;
    logic [31:0] r_dvd;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [31:0] r_a;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_b_zero;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic        r_busy;
    logic        r_finish;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_b_zero;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_a_neg  = SIGNED_OP & a[31];
    assign w_b_neg  = SIGNED_OP & b[31];
    assign w_a_mag  = w_a_neg ? (~a + 32'd1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 32'd1) : b;
    assign w_b_zero = (b == 32'd0);

    assign w_shift  = {r_rem, r_dvd[31]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[32];

    assign w_q_fix  = r_q_neg ? (~r_dvd + 32'd1) : r_dvd;
    assign w_r_fix  = r_r_neg ? (~r_rem + 32'd1) : r_rem;

    assign q      = r_q;
    assign r      = r_r;
    assign busy   = r_busy;
    assign finish = r_finish;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!cpu_stall) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
`ifdef DIV_BY_ZERO_EN
                        w_next = w_b_zero ? S_DONE : S_CALC;
`else
                        w_next = S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (r_last) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 5'd0;
            r_last   <= 1'b0;
            r_dvd    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
            r_a      <= 32'd0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_q      <= 32'd0;
            r_r      <= 32'd0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            if (!cpu_stall) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_dvd    <= w_a_mag;
                            r_rem    <= 32'd0;
                            r_dvs    <= w_b_mag;
                            r_a      <= a;
                            r_q_neg  <= w_a_neg ^ w_b_neg;
                            r_r_neg  <= w_a_neg;
                            r_b_zero <= w_b_zero;
                            r_cnt    <= 5'd0;
                            r_last   <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        // The dividend register doubles as the quotient shift register.
                        if (!r_last) begin
                            r_dvd <= {r_dvd[30:0], w_ge};
                            r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
                            r_cnt <= r_cnt + 5'd1;
                            if (r_cnt == 5'd31) begin
                                r_last <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_q      <= r_b_zero ? 32'hFFFF_FFFF : w_q_fix;
                        r_r      <= r_b_zero ? r_a : w_r_fix;
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    default: begin
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DIV_BY_ZERO_EN
    logic r_dz;
    assign dz = r_dz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dz <= 1'b0;
        end else if (!cpu_stall && (r_state == S_IDLE) && start) begin
            r_dz <= w_b_zero;
        end
    end
`endif

endmodule
